// File: rtl/ex_mem_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pkg
// Shared definitions for the EX->MEM pipeline stage:
//   - default payload / control widths
//   - control-field bit indices (memRead, memWrite, branch, regWrite, memToReg)
//   - payload field offsets and widths
//   - occupancy state encoding of the stage's two-slot buffer
// No ports (package).
// ----------------------------------------------------------------------------
package ex_mem_pkg;

    // Control field bit indices
    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_TO_REG = 4;

    // Payload field layout, LSB first
    localparam int ALU_RESULT_LSB    = 0;
    localparam int ALU_RESULT_W      = 32;
    localparam int STORE_DATA_LSB    = ALU_RESULT_LSB + ALU_RESULT_W;
    localparam int STORE_DATA_W      = 32;
    localparam int BRANCH_TARGET_LSB = STORE_DATA_LSB + STORE_DATA_W;
    localparam int BRANCH_TARGET_W   = 32;
    localparam int ZERO_FLAG_LSB     = BRANCH_TARGET_LSB + BRANCH_TARGET_W;
    localparam int ZERO_FLAG_W       = 1;
    localparam int WRITE_REG_LSB     = ZERO_FLAG_LSB + ZERO_FLAG_W;
    localparam int WRITE_REG_W       = 5;
    localparam int SPARE_LSB         = WRITE_REG_LSB + WRITE_REG_W;
    localparam int SPARE_W           = 4;

    localparam int PAYLOAD_W_DEF = SPARE_LSB + SPARE_W;   // 106
    localparam int CTRL_W_DEF    = CTRL_MEM_TO_REG + 1;   // 5

    // Buffer occupancy: EMPTY (no beat), ONE (main slot), TWO (main + skid)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/ex_mem_pipe_stage_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter, updated on the falling clock edge.
// Ports:
//   clock  in   counter clock (falling edge active)
//   clear  in   synchronous clear, active-high, has priority over inc
//   inc    in   add one when not already at all-ones
//   count  out  current count (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count with saturation at all-ones; clear wins over increment
    always_ff @(negedge clock) begin
        if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_stage
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer (main slot drives the outputs, skid slot absorbs one extra beat so
// in_ready never depends combinationally on out_ready). Supports flush and
// forces the control field to zero for every bubble.
// All state updates on the falling edge of clock; reset is synchronous,
// active-high.
//
// Optional feature macro: EX_MEM_PIPE_PERF_EN
//   adds stall_cycles / flush_drops saturating 32-bit counters.
//
// Ports:
//   clock        in   stage clock (falling edge active)
//   reset        in   synchronous reset, active-high
//   flush        in   discard all held and incoming beats
//   in_valid     in   upstream beat present
//   in_ready     out  stage can accept a beat
//   in_payload   in   upstream data   [PAYLOAD_W]
//   in_ctrl      in   upstream control [CTRL_W]
//   out_valid    out  beat presented to MEM
//   out_ready    in   MEM consumes the beat
//   out_payload  out  data to MEM     [PAYLOAD_W]
//   out_ctrl     out  control to MEM  [CTRL_W], zero when out_valid=0
//   stall_cycles out  (perf build) cycles with out_valid & !out_ready
//   flush_drops  out  (perf build) flush cycles that discarded a beat
// ----------------------------------------------------------------------------
module ex_mem_pipe_stage
    import ex_mem_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CTRL_W    = CTRL_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl
`ifdef EX_MEM_PIPE_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_drops
`endif
);

    pipe_state_e          state_r;
    logic                 main_valid_r;
    logic [PAYLOAD_W-1:0] main_payload_r;
    logic [CTRL_W-1:0]    main_ctrl_r;
    logic                 skid_valid_r;
    logic [PAYLOAD_W-1:0] skid_payload_r;
    logic [CTRL_W-1:0]    skid_ctrl_r;

    logic in_fire_s;
    logic out_fire_s;

    // Ready depends only on held state and reset, never on out_ready
    assign in_ready   = !skid_valid_r && !reset;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = main_valid_r && out_ready;

    assign out_valid   = main_valid_r;
    assign out_payload = main_payload_r;
    assign out_ctrl    = main_ctrl_r;

    // Occupancy FSM and slot storage; flush keeps payloads, clears valid/ctrl
    always_ff @(negedge clock) begin
        if (reset) begin
            state_r        <= EMPTY;
            main_valid_r   <= 1'b0;
            main_payload_r <= '0;
            main_ctrl_r    <= '0;
            skid_valid_r   <= 1'b0;
            skid_payload_r <= '0;
            skid_ctrl_r    <= '0;
        end else if (flush) begin
            state_r      <= EMPTY;
            main_valid_r <= 1'b0;
            main_ctrl_r  <= '0;
            skid_valid_r <= 1'b0;
            skid_ctrl_r  <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_r        <= ONE;
                        main_valid_r   <= 1'b1;
                        main_payload_r <= in_payload;
                        main_ctrl_r    <= in_ctrl;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_payload_r <= in_payload;
                        main_ctrl_r    <= in_ctrl;
                    end else if (in_fire_s) begin
                        // MEM stalled: park the new beat behind the main slot
                        state_r        <= TWO;
                        skid_valid_r   <= 1'b1;
                        skid_payload_r <= in_payload;
                        skid_ctrl_r    <= in_ctrl;
                    end else if (out_fire_s) begin
                        // Becoming a bubble: zero ctrl so it cannot cause side effects
                        state_r      <= EMPTY;
                        main_valid_r <= 1'b0;
                        main_ctrl_r  <= '0;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_r        <= ONE;
                        main_payload_r <= skid_payload_r;
                        main_ctrl_r    <= skid_ctrl_r;
                        skid_valid_r   <= 1'b0;
                        skid_ctrl_r    <= '0;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    state_r      <= EMPTY;
                    main_valid_r <= 1'b0;
                    main_ctrl_r  <= '0;
                    skid_valid_r <= 1'b0;
                    skid_ctrl_r  <= '0;
                end
            endcase
        end
    end

`ifdef EX_MEM_PIPE_PERF_EN
    logic stall_inc_s;
    logic drop_inc_s;

    assign stall_inc_s = main_valid_r && !out_ready;
    // A flush cycle counts as a drop only if something was actually discarded
    assign drop_inc_s  = flush && (main_valid_r || skid_valid_r || in_fire_s);

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (stall_inc_s),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(32)) u_drop_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (drop_inc_s),
        .count (flush_drops)
    );
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_pipe_stage
// Scoreboard bench: every accepted beat is pushed to an expected queue; the
// queue head must be presented on the outputs and is popped on out_fire.
// Flush and reset empty the queue. A small stand-alone sat_counter instance
// exercises saturation. Perf counters are checked when EX_MEM_PIPE_PERF_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_ex_mem_pipe_stage;
    import ex_mem_pkg::*;

    localparam int PW = PAYLOAD_W_DEF;
    localparam int CW = CTRL_W_DEF;
    localparam int BW = PW + CW;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] out_ctrl;
`ifdef EX_MEM_PIPE_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   flush_drops;
    logic [31:0]   exp_stall;
    logic [31:0]   exp_drop;
`endif

    logic          sc_clear;
    logic          sc_inc;
    logic [3:0]    sc_count;
    logic [3:0]    sc_exp;

    logic [BW-1:0] q[$];
    int            checks;
    int            errors;

    ex_mem_pipe_stage dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_ctrl    (out_ctrl)
`ifdef EX_MEM_PIPE_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_drops (flush_drops)
`endif
    );

    sat_counter #(.WIDTH(4)) u_sat (
        .clock (clock),
        .clear (sc_clear),
        .inc   (sc_inc),
        .count (sc_count)
    );

    // Free-running clock; DUT state changes on the falling edge
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk_payload(input logic [31:0] alu, input logic [31:0] st);
        logic [PW-1:0] p;
        p = '0;
        p[ALU_RESULT_LSB +: ALU_RESULT_W]       = alu;
        p[STORE_DATA_LSB +: STORE_DATA_W]       = st;
        p[BRANCH_TARGET_LSB +: BRANCH_TARGET_W] = alu ^ 32'hA5A5_0000;
        p[ZERO_FLAG_LSB]                        = (alu == 32'd0);
        p[WRITE_REG_LSB +: WRITE_REG_W]         = alu[4:0];
        return p;
    endfunction

    // One cycle: drive at posedge, check outputs vs. scoreboard, update model
    task automatic step(input logic iv, input logic [PW-1:0] ip, input logic [CW-1:0] ic,
                        input logic ordy, input logic fl, input logic rs);
        logic [BW-1:0] head;
        logic          ifire;
        logic          ofire;
        @(posedge clock);
        in_valid   = iv;
        in_payload = ip;
        in_ctrl    = ic;
        out_ready  = ordy;
        flush      = fl;
        reset      = rs;
        #1;
        check("in_ready", {127'd0, in_ready}, {127'd0, ((q.size() < 2) && !rs)});
        check("out_valid", {127'd0, out_valid}, {127'd0, (q.size() > 0)});
        if (q.size() > 0) begin
            head = q[0];
            check("out_payload", {22'd0, out_payload}, {22'd0, head[PW-1:0]});
            check("out_ctrl", {123'd0, out_ctrl}, {123'd0, head[BW-1:PW]});
        end else begin
            check("bubble_ctrl", {123'd0, out_ctrl}, 128'd0);
        end
        ifire = (q.size() < 2) && !rs && iv;
        ofire = (q.size() > 0) && ordy;
`ifdef EX_MEM_PIPE_PERF_EN
        check("stall_cycles", {96'd0, stall_cycles}, {96'd0, exp_stall});
        check("flush_drops", {96'd0, flush_drops}, {96'd0, exp_drop});
        if (rs) begin
            exp_stall = 32'd0;
            exp_drop  = 32'd0;
        end else begin
            if ((q.size() > 0) && !ordy && (exp_stall != 32'hFFFF_FFFF)) exp_stall = exp_stall + 32'd1;
            if (fl && ((q.size() > 0) || ifire) && (exp_drop != 32'hFFFF_FFFF)) exp_drop = exp_drop + 32'd1;
        end
`endif
        if (ofire) void'(q.pop_front());
        if (rs || fl) q.delete();
        else if (ifire) q.push_back({ic, ip});
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 5'd0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [CW-1:0] rc;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_payload = '0;
        in_ctrl    = '0;
        out_ready  = 1'b0;
        sc_clear   = 1'b1;
        sc_inc     = 1'b0;
        sc_exp     = 4'd0;
`ifdef EX_MEM_PIPE_PERF_EN
        exp_stall  = 32'd0;
        exp_drop   = 32'd0;
`endif
        // Initial reset, not scored while state is still unknown
        repeat (3) @(negedge clock);
        #1;
        check("rst_payload", {22'd0, out_payload}, 128'd0);

        // Single beat, then back-to-back beats 1..8 at full throughput
        step(1'b1, mk_payload(32'h0000_0010, 32'h0), 5'b01001, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            step(1'b1, mk_payload(i, 32'h1000 + i), 5'(i), 1'b1, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Back-pressure: A, B fill both slots, C waits upstream
        step(1'b1, mk_payload(32'hAAAA, 32'h1), 5'b00011, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_payload(32'hBBBB, 32'h2), 5'b00101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, mk_payload(32'hCCCC, 32'h3), 5'b01010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, mk_payload(32'hCCCC, 32'h3), 5'b01010, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Flush while full, with a new beat offered
        step(1'b1, mk_payload(32'hD0D0, 32'h4), 5'b10001, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_payload(32'hE0E0, 32'h5), 5'b10010, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_payload(32'hF0F0, 32'h6), 5'b10100, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Drain a ctrl=11111 beat to empty: bubble must show ctrl 0
        step(1'b1, mk_payload(32'h1F1F, 32'h7), 5'b11111, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 2);

        // Reset in ONE with MEM stalled and upstream still offering
        step(1'b1, mk_payload(32'h2222, 32'h8), 5'b01100, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_payload(32'h3333, 32'h9), 5'b01101, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        #1;
        check("rst_mid_payload", {22'd0, out_payload}, 128'd0);
        idle(1'b1, 2);

        // Reset and flush together: reset wins, same outcome
        step(1'b1, mk_payload(32'h4444, 32'hA), 5'b00001, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_payload(32'h5555, 32'hB), 5'b00010, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Long stall for the stall counter
        step(1'b1, mk_payload(32'h6666, 32'hC), 5'b00100, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 40);
`ifdef EX_MEM_PIPE_PERF_EN
        check("stall_40", {96'd0, stall_cycles}, {96'd0, exp_stall});
`endif
        idle(1'b1, 2);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            rc = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), mk_payload($urandom, $urandom), rc,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
        end
        idle(1'b1, 3);

        // Saturating counter: runs past all-ones and must stick there
        @(posedge clock);
        sc_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            sc_inc = 1'b1;
            #1;
            check("sat_count", {124'd0, sc_count}, {124'd0, sc_exp});
            if (sc_exp != 4'hF) sc_exp = sc_exp + 4'd1;
        end
        @(posedge clock);
        sc_clear = 1'b1;
        #1;
        check("sat_hold", {124'd0, sc_count}, {124'd0, sc_exp});
        @(posedge clock);
        sc_clear = 1'b0;
        sc_inc   = 1'b0;
        #1;
        check("sat_clear", {124'd0, sc_count}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
